// File: rtl/mod14_pkg.sv
// Purpose : shared constants, types and helpers for the mod-14 counter block.
// Latency : n/a (definitions only).
// Backpressure: n/a; the counter free-runs and has no flow control.
package mod14_pkg;

  // Fixed modulus and the width needed to hold 0..MODULUS-1.
  localparam int MODULUS = 14;
  localparam int WIDTH   = 4;
  localparam int LAST    = MODULUS - 1;

  typedef logic [WIDTH-1:0]   count_t;
  typedef logic [MODULUS-1:0] onehot_t;

  localparam count_t LAST_CNT = count_t'(LAST);

  // One-hot image of a count value. Values >= MODULUS shift the bit out of
  // range and yield all zeros; callers only pass legal counts.
  function automatic onehot_t onehot_of(input count_t c);
    return onehot_t'(1) << c;
  endfunction

endpackage

// File: rtl/mod14_next.sv
// Purpose : combinational next-state and output decode for the mod-14 counter.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; every clock edge consumes the next state.
//
// Ports:
//   count_i    - current registered count
//   count_d_o  - next count (0..13, illegal 14/15 recover to 0)
//   tc_o       - terminal count, high while count_i == 13
//   onehot_d_o - one-hot image of count_d_o
//   wrap_d_o   - next value of the wrap pulse register
module mod14_next
  import mod14_pkg::*;
(
  input  logic [WIDTH-1:0]   count_i,
  output logic [WIDTH-1:0]   count_d_o,
  output logic               tc_o,
  output logic [MODULUS-1:0] onehot_d_o,
  output logic               wrap_d_o
);

  logic at_last;

  always_comb begin
    at_last    = (count_i == LAST_CNT);
    count_d_o  = '0;
    tc_o       = at_last;
    // Only a genuine 13 -> 0 transition pulses wrap; recovering from an
    // illegal 14/15 also lands on 0 but is not a wrap.
    wrap_d_o   = at_last;
    // ">=" folds the normal wrap and illegal-state recovery into one compare.
    if (count_i >= LAST_CNT) begin
      count_d_o = '0;
    end else begin
      count_d_o = count_i + count_t'(1);
    end
    onehot_d_o = onehot_of(count_d_o);
  end

endmodule

// File: rtl/mod14_counter.sv
// Purpose : free-running modulo-14 counter with tc decode, wrap pulse and one-hot copy.
// Latency : count/onehot/wrap registered (1 edge); tc combinational from count.
// Backpressure: none; advances on every rising clk edge while reset is low.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous reset, ACTIVE HIGH despite the name (asserted at 1);
//            release must be synchronized externally
//   count  - registered count 0..13
//   tc     - high while count == 13
//   wrap   - one-cycle pulse in the cycle after count moves 13 -> 0
//   onehot - registered one-hot copy of count
module mod14_counter
  import mod14_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic               wrap,
  output logic [MODULUS-1:0] onehot
);

  logic [WIDTH-1:0]   count_q;
  logic [WIDTH-1:0]   count_d;
  logic [MODULUS-1:0] onehot_q;
  logic [MODULUS-1:0] onehot_d;
  logic               wrap_q;
  logic               wrap_d;

  mod14_next u_next (
    .count_i    (count_q),
    .count_d_o  (count_d),
    .tc_o       (tc),
    .onehot_d_o (onehot_d),
    .wrap_d_o   (wrap_d)
  );

  // count, onehot and wrap form one register group so they always move together.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count_q  <= '0;
      onehot_q <= onehot_t'(1);
      wrap_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      onehot_q <= onehot_d;
      wrap_q   <= wrap_d;
    end
  end

  assign count  = count_q;
  assign onehot = onehot_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_mod14_counter.sv
// Purpose : self-checking bench for mod14_counter using an expected-value queue.
// Latency : expects count/onehot/wrap updated one edge after each push.
// Backpressure: n/a.
module tb_mod14_counter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  count;
  logic        tc;
  logic        wrap;
  logic [13:0] onehot;

  int checks = 0;
  int errors = 0;
  bit inv_en = 1'b0;

  typedef struct packed {
    logic [3:0]  cnt;
    logic        wrp;
    logic [13:0] oh;
    logic        tcv;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state.
  int m_count = 0;
  bit m_wrap  = 1'b0;

  mod14_counter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .count  (count),
    .tc     (tc),
    .wrap   (wrap),
    .onehot (onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare all outputs against the model's current state.
  task automatic chk_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(m_count));
    chk({tag, "_onehot"}, 32'(onehot), 32'(14'(1) << m_count));
    chk({tag, "_wrap"}, 32'(wrap), 32'(m_wrap));
    chk({tag, "_tc"}, 32'(tc), 32'(m_count == 13));
  endtask

  // One clock edge: model predicts and pushes, DUT result is popped and compared.
  task automatic step();
    exp_t e;
    int   nxt;
    nxt   = (m_count >= 13) ? 0 : m_count + 1;
    e.cnt = 4'(nxt);
    e.wrp = (m_count == 13);
    e.oh  = 14'(1) << nxt;
    e.tcv = (nxt == 13);
    sb_q.push_back(e);
    m_count = nxt;
    m_wrap  = e.wrp;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("sb_count", 32'(count), 32'(e.cnt));
      chk("sb_onehot", 32'(onehot), 32'(e.oh));
      chk("sb_wrap", 32'(wrap), 32'(e.wrp));
      chk("sb_tc", 32'(tc), 32'(e.tcv));
    end
  endtask

  // Structural invariants every cycle while enabled.
  always @(negedge clk) begin
    if (inv_en) begin
      chk("inv_onehot", 32'(onehot), 32'(14'(1) << count));
      chk("inv_range", 32'(count <= 4'd13), 32'd1);
      chk("inv_tc", 32'(tc), 32'(count == 4'd13));
    end
  end

  // Watchdog: the run must always terminate.
  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held: outputs at reset values regardless of clock.
    rst_n = 1'b1;
    #1;
    chk_state("rst_t1");
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_state("rst_held");
    end

    // Release between edges; first edge must give count 1.
    @(negedge clk);
    rst_n  = 1'b0;
    inv_en = 1'b1;
    #1;
    chk_state("rel");

    // Free run: 30 edges, including two wraps.
    repeat (30) step();
    chk("free_final", 32'(count), 32'd2);

    // Advance to 9, then assert reset mid-cycle.
    while (m_count != 9) step();
    #2;
    rst_n = 1'b1;
    #1;
    m_count = 0;
    m_wrap  = 1'b0;
    chk_state("midrst_async");
    @(posedge clk);
    #1;
    chk_state("midrst_held");
    @(negedge clk);
    rst_n = 1'b0;
    step();
    chk("midrst_first", 32'(count), 32'd1);

    // Run into another wrap; step checks tc at 13, wrap pulse, then wrap low.
    while (m_count != 13) step();
    chk("wrap_tc13", 32'(tc), 32'd1);
    step();
    chk("wrap_pulse", 32'(wrap), 32'd1);
    step();
    chk("wrap_clear", 32'(wrap), 32'd0);

    // Illegal-state recovery from 15.
    @(negedge clk);
    inv_en = 1'b0;
    #2;
    force dut.count_q = 4'd15;
    #1;
    chk("ill_forced", 32'(count), 32'd15);
    chk("ill_tc", 32'(tc), 32'd0);
    release dut.count_q;
    #1;
    m_count = 15;
    step();
    chk("ill_recover", 32'(count), 32'd0);
    chk("ill_onehot", 32'(onehot), 32'h0001);
    chk("ill_nowrap", 32'(wrap), 32'd0);
    inv_en = 1'b1;
    repeat (3) step();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    inv_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
